// File: rtl/ines_rom_loader_pkg.sv
// Shared types and constants for the iNES ROM loader.
package nes_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PRG     = 3'd2,
    ST_CHR     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5,
    ST_TRAINER = 3'd6
  } loader_state_t;

  localparam logic [31:0] INES_MAGIC = 32'h4E45_531A;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MAGIC     = 2'd1;
  localparam logic [1:0] ERR_PRG_BANKS = 2'd2;
  localparam logic [1:0] ERR_CHR_BANKS = 2'd3;
  // Trainer rejects carry code 0; STATUS[9] distinguishes them from "no error".
  localparam logic [1:0] ERR_TRAINER   = 2'd0;

  localparam logic [16:0] PRG_BANK_BYTES = 17'd16384;
  localparam logic [16:0] CHR_BANK_BYTES = 17'd8192;
  localparam logic [16:0] TRAINER_BYTES  = 17'd512;

  // Expected magic byte at header offset idx (file order 'N','E','S',0x1A).
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_rom_loader_if.sv
// Avalon-MM slave bus bundle for the iNES ROM loader.
interface ines_rom_loader_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/ines_rom_loader_header_capture.sv
// iNES header capture: tracks the 16-byte header index, latches the fields
// the loader needs and flags the first offending byte.
// Build option TRAINER_SKIP_EN: when undefined, a trainer flag in byte 6 is
// rejected here; when defined it is only recorded for the loader FSM.
module ines_header_capture
  import nes_loader_pkg::*;
#(
  parameter int unsigned MAX_PRG_BANKS = 2,
  parameter int unsigned MAX_CHR_BANKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       hdr_done,
  output logic       hdr_err,
  output logic [1:0] err_code,
  output logic       trainer_rej,
  output logic [7:0] prg_banks,
  output logic [7:0] chr_banks,
  output logic       trainer,
  output logic       mirroring,
  output logic [7:0] mapper
);

  localparam logic [7:0] MAX_PRG = 8'(MAX_PRG_BANKS);
  localparam logic [7:0] MAX_CHR = 8'(MAX_CHR_BANKS);

  logic [3:0] idx;

  // Validate the incoming byte against the rule for its header offset.
  always_comb begin
    hdr_err     = 1'b0;
    err_code    = ERR_NONE;
    trainer_rej = 1'b0;
    if (byte_valid) begin
      case (idx)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          if (byte_in != magic_byte(idx[1:0])) begin
            hdr_err  = 1'b1;
            err_code = ERR_MAGIC;
          end
        end
        4'd4: begin
          if (byte_in == 8'd0 || byte_in > MAX_PRG) begin
            hdr_err  = 1'b1;
            err_code = ERR_PRG_BANKS;
          end
        end
        4'd5: begin
          if (byte_in > MAX_CHR) begin
            hdr_err  = 1'b1;
            err_code = ERR_CHR_BANKS;
          end
        end
`ifndef TRAINER_SKIP_EN
        4'd6: begin
          if (byte_in[2]) begin
            hdr_err     = 1'b1;
            err_code    = ERR_TRAINER;
            trainer_rej = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    hdr_done = byte_valid && (idx == 4'd15) && !hdr_err;
  end

  // Header index and field registers; an offending byte is not consumed.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      idx       <= 4'd0;
      prg_banks <= 8'd0;
      chr_banks <= 8'd0;
      trainer   <= 1'b0;
      mirroring <= 1'b0;
      mapper    <= 8'd0;
    end else if (byte_valid && !hdr_err) begin
      idx <= idx + 4'd1;
      case (idx)
        4'd4: prg_banks <= byte_in;
        4'd5: chr_banks <= byte_in;
        4'd6: begin
          mirroring   <= byte_in[0];
          trainer     <= byte_in[2];
          mapper[3:0] <= byte_in[7:4];
        end
        4'd7: mapper[7:4] <= byte_in[7:4];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ines_rom_loader.sv
// iNES ROM loader: Avalon-MM slave that takes a raw .nes file one byte per
// DATA write, validates the header, streams PRG then CHR payload into the
// game ROMs and holds the NES CPU in reset until the load is complete.
// Build option TRAINER_SKIP_EN: when defined, a 512-byte trainer is skipped
// instead of being rejected.
//
//   state   | meaning
//   IDLE    | after reset, waiting for a CONTROL start
//   HEADER  | consuming the 16-byte iNES header
//   TRAINER | discarding the 512-byte trainer (TRAINER_SKIP_EN only)
//   PRG     | writing PRG ROM bytes
//   CHR     | writing CHR ROM bytes
//   DONE    | load complete, CPU released
//   ERROR   | header rejected, sticky until CONTROL start or Reset
module ines_rom_loader
  import nes_loader_pkg::*;
#(
  parameter int unsigned MAX_PRG_BANKS = 2,
  parameter int unsigned MAX_CHR_BANKS = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  ines_rom_loader_if.slave   bus,
  output logic [15:0]        rom_addr,
  output logic [7:0]         rom_data,
  output logic               prg_rom_write,
  output logic               chr_rom_write,
  output logic               cpu_hold,
  output logic               mirroring,
  output logic [7:0]         mapper
);

  loader_state_t state;
  logic [15:0]   addr;
  logic [16:0]   remaining;
  logic [1:0]    err_q;
  logic          trainer_rej_q;

  logic          data_wr;
  logic          start;
  logic [7:0]    data_byte;
  logic          hdr_done;
  logic          hdr_err;
  logic [1:0]    hdr_err_code;
  logic          hdr_trainer_rej;
  logic [7:0]    hdr_prg_banks;
  logic [7:0]    hdr_chr_banks;
  logic          hdr_trainer;
  logic [16:0]   prg_total;
  logic [16:0]   chr_total;
  logic [15:0]   addr_next;
  logic [16:0]   count;

  assign data_wr   = bus.avs_write && (bus.avs_address == REG_DATA);
  assign start     = bus.avs_write && (bus.avs_address == REG_CONTROL) && bus.avs_writedata[0];
  assign data_byte = bus.avs_writedata[7:0];
  assign prg_total = PRG_BANK_BYTES * {9'd0, hdr_prg_banks};
  assign chr_total = CHR_BANK_BYTES * {9'd0, hdr_chr_banks};
  // Saturate rather than wrap at the top of the address space.
  assign addr_next = (addr == 16'hFFFF) ? addr : addr + 16'd1;
  assign count     = (state == ST_PRG || state == ST_CHR) ? remaining : 17'd0;

  logic unused_bits;
`ifdef TRAINER_SKIP_EN
  assign unused_bits = ^bus.avs_writedata[31:8];
`else
  assign unused_bits = ^{bus.avs_writedata[31:8], hdr_trainer};
`endif

  ines_header_capture #(
    .MAX_PRG_BANKS (MAX_PRG_BANKS),
    .MAX_CHR_BANKS (MAX_CHR_BANKS)
  ) u_hdr (
    .clk         (Clk),
    .reset       (Reset),
    .start       (start),
    .byte_valid  (data_wr && state == ST_HEADER),
    .byte_in     (data_byte),
    .hdr_done    (hdr_done),
    .hdr_err     (hdr_err),
    .err_code    (hdr_err_code),
    .trainer_rej (hdr_trainer_rej),
    .prg_banks   (hdr_prg_banks),
    .chr_banks   (hdr_chr_banks),
    .trainer     (hdr_trainer),
    .mirroring   (mirroring),
    .mapper      (mapper)
  );

  // Load sequencer: section routing, address/remaining counters, strobes, CPU hold.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      addr          <= 16'd0;
      remaining     <= 17'd0;
      err_q         <= ERR_NONE;
      trainer_rej_q <= 1'b0;
      rom_addr      <= 16'd0;
      rom_data      <= 8'd0;
      prg_rom_write <= 1'b0;
      chr_rom_write <= 1'b0;
      cpu_hold      <= 1'b1;
    end else begin
      prg_rom_write <= 1'b0;
      chr_rom_write <= 1'b0;
      cpu_hold      <= 1'b1;
      if (start) begin
        state         <= ST_HEADER;
        addr          <= 16'd0;
        remaining     <= 17'd0;
        err_q         <= ERR_NONE;
        trainer_rej_q <= 1'b0;
      end else begin
        case (state)
          ST_HEADER: begin
            if (hdr_err) begin
              state         <= ST_ERROR;
              err_q         <= hdr_err_code;
              trainer_rej_q <= hdr_trainer_rej;
            end else if (hdr_done) begin
`ifdef TRAINER_SKIP_EN
              if (hdr_trainer) begin
                state     <= ST_TRAINER;
                remaining <= TRAINER_BYTES;
              end else
`endif
              begin
                state     <= ST_PRG;
                addr      <= 16'd0;
                remaining <= prg_total;
              end
            end
          end
          ST_TRAINER: begin
            if (data_wr) begin
              if (remaining == 17'd1) begin
                state     <= ST_PRG;
                addr      <= 16'd0;
                remaining <= prg_total;
              end else begin
                remaining <= remaining - 17'd1;
              end
            end
          end
          ST_PRG: begin
            if (data_wr) begin
              rom_addr      <= addr;
              rom_data      <= data_byte;
              prg_rom_write <= 1'b1;
              if (remaining == 17'd1) begin
                if (hdr_chr_banks == 8'd0) begin
                  state     <= ST_DONE;
                  remaining <= 17'd0;
                end else begin
                  state     <= ST_CHR;
                  addr      <= 16'd0;
                  remaining <= chr_total;
                end
              end else begin
                addr      <= addr_next;
                remaining <= remaining - 17'd1;
              end
            end
          end
          ST_CHR: begin
            if (data_wr) begin
              rom_addr      <= addr;
              rom_data      <= data_byte;
              chr_rom_write <= 1'b1;
              if (remaining == 17'd1) begin
                state     <= ST_DONE;
                remaining <= 17'd0;
              end else begin
                addr      <= addr_next;
                remaining <= remaining - 17'd1;
              end
            end
          end
          ST_DONE: cpu_hold <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Register read port: data is presented the cycle after avs_read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.avs_readdata <= 32'd0;
    end else if (bus.avs_read) begin
      case (bus.avs_address)
        REG_STATUS: bus.avs_readdata <= {22'd0, trainer_rej_q, cpu_hold, 2'b00, err_q, 1'b0, state};
        REG_COUNT:  bus.avs_readdata <= {15'd0, count};
        default:    bus.avs_readdata <= 32'd0;
      endcase
    end
  end

endmodule
